// File: rtl/stream_permutation_buffer.sv
// Ping-pong permutation buffer: frames are written in natural order into one
// bank while the previously completed frame is read out of the other bank in
// identity, bit-reversed or stride-gather order.
module stream_permutation_buffer #(
   parameter int unsigned DATA_WIDTH = 28,
   parameter int unsigned N_POINTS   = 128,
   parameter int unsigned STRIDE     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_start,
   input  logic [1:0]            in_mode,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_start,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  frame_abort
);

   localparam int unsigned AW = $clog2(N_POINTS);
   localparam int unsigned SW = $clog2(STRIDE);
   localparam int unsigned MW = AW - SW;
   localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

   typedef enum logic {WR_IDLE, WR_FILL}  wr_state_t;
   typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

   logic [DATA_WIDTH-1:0] mem_q [2*N_POINTS];

   wr_state_t             wr_state_q, wr_state_d;
   logic [AW-1:0]         wr_cnt_q,   wr_cnt_d;
   logic                  wr_bank_q,  wr_bank_d;
   logic [1:0]            wr_mode_q,  wr_mode_d;

   rd_state_t             rd_state_q, rd_state_d;
   logic [AW-1:0]         rd_cnt_q,   rd_cnt_d;
   logic                  rd_bank_q,  rd_bank_d;
   logic [1:0]            rd_mode_q,  rd_mode_d;

   logic                  out_start_q, out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic                  wr_en_c;
   logic [AW-1:0]         wr_addr_c;
   logic                  handoff_c;
   logic                  abort_c;
   logic                  rd_en_c;
   logic [AW-1:0]         perm_c;

   // Writer: natural-order fill, restart on early in_start, hand bank over on last word
   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      wr_mode_d  = wr_mode_q;
      wr_en_c    = 1'b0;
      wr_addr_c  = wr_cnt_q;
      handoff_c  = 1'b0;
      abort_c    = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (in_start) begin
               wr_en_c    = 1'b1;
               wr_addr_c  = '0;
               wr_cnt_d   = AW'(1);
               wr_mode_d  = in_mode;
               wr_state_d = WR_FILL;
            end
         end
         WR_FILL: begin
            wr_en_c = 1'b1;
            if (in_start && (wr_cnt_q != LAST)) begin
               // partial frame dropped; same bank restarts from address 0
               abort_c   = 1'b1;
               wr_addr_c = '0;
               wr_cnt_d  = AW'(1);
               wr_mode_d = in_mode;
            end else if (wr_cnt_q == LAST) begin
               handoff_c  = 1'b1;
               wr_cnt_d   = '0;
               wr_bank_d  = ~wr_bank_q;
               wr_state_d = WR_IDLE;
            end else begin
               wr_cnt_d = wr_cnt_q + AW'(1);
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Reader: drains a handed-over bank, chaining straight into the next one if ready
   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_bank_d  = rd_bank_q;
      rd_mode_d  = rd_mode_q;
      rd_en_c    = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (handoff_c) begin
               rd_state_d = RD_DRAIN;
               rd_cnt_d   = '0;
               rd_bank_d  = wr_bank_q;
               rd_mode_d  = wr_mode_q;
            end
         end
         RD_DRAIN: begin
            rd_en_c = 1'b1;
            if (rd_cnt_q == LAST) begin
               rd_cnt_d = '0;
               if (handoff_c) begin
                  rd_bank_d = wr_bank_q;
                  rd_mode_d = wr_mode_q;
               end else begin
                  rd_state_d = RD_IDLE;
               end
            end else begin
               rd_cnt_d = rd_cnt_q + AW'(1);
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Read address permutation for the frame being drained
   always_comb begin
      perm_c = rd_cnt_q;
      case (rd_mode_q)
         2'd1: begin
            for (int i = 0; i < int'(AW); i++) begin
               perm_c[i] = rd_cnt_q[int'(AW) - 1 - i];
            end
         end
         // (j mod M)*S + j/M with M, S powers of two is a bit rotation
         2'd2:    perm_c = {rd_cnt_q[MW-1:0], rd_cnt_q[AW-1:MW]};
         default: perm_c = rd_cnt_q;
      endcase
   end

   // Frame storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_c && !rst) begin
         mem_q[{wr_bank_q, wr_addr_c}] <= in_data;
      end
   end

   // Control state and registered read/output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= WR_IDLE;
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         wr_mode_q   <= '0;
         rd_state_q  <= RD_IDLE;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_mode_q   <= '0;
         out_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         wr_mode_q   <= wr_mode_d;
         rd_state_q  <= rd_state_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_bank_q   <= rd_bank_d;
         rd_mode_q   <= rd_mode_d;
         out_start_q <= rd_en_c && (rd_cnt_q == '0);
         out_valid_q <= rd_en_c;
         out_data_q  <= rd_en_c ? mem_q[{rd_bank_q, perm_c}] : '0;
      end
   end

   // Abort is flagged in the same cycle as the restarting in_start
   assign frame_abort = abort_c && !rst;
   assign out_start   = out_start_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;

endmodule

// File: tb/tb_stream_permutation_buffer.sv
// Directed and randomised checks of the permutation buffer with N_POINTS=8, STRIDE=2.
module tb_stream_permutation_buffer;

   localparam int DW   = 28;
   localparam int N    = 8;
   localparam int S    = 2;
   localparam int M    = N / S;
   localparam int MAXC = 4096;

   logic          clk;
   logic          rst;
   logic          in_start;
   logic [1:0]    in_mode;
   logic [DW-1:0] in_data;
   logic          out_start;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          frame_abort;

   // per-cycle stimulus; observed/expected packed as {abort, start, valid, data}
   logic          s_start [MAXC];
   logic [1:0]    s_mode  [MAXC];
   logic [DW-1:0] s_data  [MAXC];
   logic          s_rst   [MAXC];
   logic [DW+2:0] obs     [MAXC];
   logic [DW+2:0] exp_v   [MAXC];

   int errors;
   int checks;

   stream_permutation_buffer #(
      .DATA_WIDTH (DW),
      .N_POINTS   (N),
      .STRIDE     (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_start    (in_start),
      .in_mode     (in_mode),
      .in_data     (in_data),
      .out_start   (out_start),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .frame_abort (frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         s_start[i] = 1'b0;
         s_mode[i]  = 2'd1;
         s_data[i]  = DW'(28'h5A5A5A5);
         s_rst[i]   = 1'b0;
         obs[i]     = '0;
         exp_v[i]   = '0;
      end
   endtask

   task automatic put_out(input int c, input logic st, input int d);
      exp_v[c] = {1'b0, st, 1'b1, DW'(d)};
   endtask

   task automatic put_frame(input int c, input logic [1:0] mode, input int base);
      s_start[c] = 1'b1;
      s_mode[c]  = mode;
      for (int k = 0; k < N; k++) s_data[c + k] = DW'(base + k);
   endtask

   // Reset for two cycles, then play cycles 0..len-1 and record outputs mid-cycle
   task automatic run(input int len);
      rst      = 1'b1;
      in_start = 1'b0;
      in_mode  = 2'd0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < len; c++) begin
         rst      = s_rst[c];
         in_start = s_start[c];
         in_mode  = s_mode[c];
         in_data  = s_data[c];
         @(negedge clk);
         obs[c] = {frame_abort, out_start, out_valid, out_data};
         @(posedge clk);
         #1;
      end
      in_start = 1'b0;
   endtask

   function automatic int ref_perm(input int mode, input int j);
      int r;
      r = j;
      if (mode == 1) begin
         r = 0;
         for (int b = 0; b < 3; b++) if (((j >> b) & 1) == 1) r = r | (1 << (2 - b));
      end else if (mode == 2) begin
         r = (j % M) * S + j / M;
      end
      return r;
   endfunction

   task automatic test_reset();
      clear_stim();
      for (int c = 0; c < 6; c++) s_rst[c] = 1'b1;
      s_start[1] = 1'b1;
      s_start[3] = 1'b1;
      put_frame(8, 2'd0, 0);
      s_rst[11] = 1'b1;
      run(30);
      for (int c = 0; c < 30; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL reset c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_bitrev();
      int e[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      clear_stim();
      put_frame(0, 2'd1, 0);
      for (int j = 0; j < N; j++) put_out(9 + j, j == 0, e[j]);
      run(20);
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL bitrev c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_modes();
      int e[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
      clear_stim();
      put_frame(0, 2'd2, 0);
      put_frame(8, 2'd0, 0);
      put_frame(16, 2'd3, 0);
      for (int j = 0; j < N; j++) begin
         put_out(9 + j, j == 0, e[j]);
         put_out(17 + j, j == 0, j);
         put_out(25 + j, j == 0, j);
      end
      run(36);
      for (int c = 0; c < 36; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL modes c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int e[8] = '{10, 14, 12, 16, 11, 15, 13, 17};
      clear_stim();
      put_frame(0, 2'd0, 0);
      put_frame(8, 2'd1, 10);
      for (int j = 0; j < N; j++) begin
         put_out(9 + j, j == 0, j);
         put_out(17 + j, j == 0, e[j]);
      end
      run(28);
      for (int c = 0; c < 28; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL back_to_back c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_abort();
      int e[8] = '{20, 24, 22, 26, 21, 25, 23, 27};
      clear_stim();
      put_frame(0, 2'd0, 90);
      put_frame(3, 2'd1, 20);
      exp_v[3][30] = 1'b1;
      for (int j = 0; j < N; j++) put_out(12 + j, j == 0, e[j]);
      run(24);
      for (int c = 0; c < 24; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL abort c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_start_at_last();
      int e[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      clear_stim();
      put_frame(0, 2'd1, 0);
      s_start[7] = 1'b1;
      s_mode[7]  = 2'd2;
      for (int j = 0; j < N; j++) put_out(9 + j, j == 0, e[j]);
      run(22);
      for (int c = 0; c < 22; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL start_at_last c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int e[8] = '{30, 32, 34, 36, 31, 33, 35, 37};
      clear_stim();
      put_frame(0, 2'd1, 0);
      s_rst[11] = 1'b1;
      put_out(9, 1'b1, 0);
      put_out(10, 1'b0, 4);
      put_out(11, 1'b0, 2);
      put_frame(14, 2'd2, 30);
      for (int j = 0; j < N; j++) put_out(23 + j, j == 0, e[j]);
      run(34);
      for (int c = 0; c < 34; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL mid_reset c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   task automatic test_random();
      int t;
      int s;
      int m;
      int a;
      int frames;
      int len;
      clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         s_data[i] = DW'($urandom);
         s_mode[i] = 2'($urandom_range(0, 3));
      end
      t      = 0;
      frames = 0;
      while (frames < 200 && t < MAXC - 64) begin
         t = t + (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3)));
         s = t;
         forever begin
            m          = int'($urandom_range(0, 3));
            s_start[s] = 1'b1;
            s_mode[s]  = 2'(m);
            if ($urandom_range(0, 5) == 0) begin
               a = int'($urandom_range(1, N - 2));
               exp_v[s + a][30] = 1'b1;
               s = s + a;
            end else begin
               if ($urandom_range(0, 3) == 0) s_start[s + N - 1] = 1'b1;
               for (int j = 0; j < N; j++) begin
                  exp_v[s + N + 1 + j][29:0] = {j == 0, 1'b1, s_data[s + ref_perm(m, j)]};
               end
               break;
            end
         end
         t = s + N;
         frames++;
      end
      len = t + 2 * N + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         checks++;
         if (obs[c] !== exp_v[c]) begin
            errors++;
            $display("FAIL random c%0d: got a=%0b s=%0b v=%0b d=%0d want a=%0b s=%0b v=%0b d=%0d", c,
                     obs[c][30], obs[c][29], obs[c][28], obs[c][27:0],
                     exp_v[c][30], exp_v[c][29], exp_v[c][28], exp_v[c][27:0]);
         end
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst      = 1'b1;
      in_start = 1'b0;
      in_mode  = 2'd0;
      in_data  = '0;
      test_reset();
      test_bitrev();
      test_modes();
      test_back_to_back();
      test_abort();
      test_start_at_last();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
